// File: rtl/autoapproach_pkg.sv
// Shared definitions for the waveform sample buffer: refresh FSM encoding and
// the RAM-reads-per-sample helper.
package autoapproach_pkg;

    typedef enum logic [1:0] {
        RF_IDLE          = 2'd0,
        RF_REQ           = 2'd1,
        RF_WAIT_DEASSERT = 2'd2
    } refresh_state_e;

    // Number of RAM reads needed to assemble one sample.
    function automatic int unsigned parts_f(input int unsigned word_wid,
                                            input int unsigned ram_word_wid);
        return (word_wid + ram_word_wid - 1) / ram_word_wid;
    endfunction

endpackage

// File: rtl/waveform_bram_buffer_if.sv
// DMA read port between the sample buffer (master) and the RAM arbiter (slave).
interface waveform_bram_buffer_if #(
    parameter int unsigned RAM_WID      = 32,
    parameter int unsigned RAM_WORD_WID = 16
) ();

    logic [RAM_WID-1:0]      ram_dma_addr;
    logic [RAM_WORD_WID-1:0] ram_word;
    logic                    ram_read;
    logic                    ram_valid;

    modport master (
        output ram_dma_addr,
        output ram_read,
        input  ram_word,
        input  ram_valid
    );

    modport slave (
        input  ram_dma_addr,
        input  ram_read,
        output ram_word,
        output ram_valid
    );

endinterface

// File: rtl/wave_bank_ram.sv
// Two-bank sample store: byte-enabled write port for part assembly, registered
// read port. Address is {bank, index}; WORD_WID is a multiple of 8.
module wave_bank_ram #(
    parameter int unsigned WORD_WID = 24,
    parameter int unsigned ADDR_WID = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_WID-1:0]         wr_addr,
    input  logic [WORD_WID-1:0]         wr_data,
    input  logic [(WORD_WID+7)/8-1:0]   wr_be,
    input  logic                        rd_en,
    input  logic [ADDR_WID-1:0]         rd_addr,
    output logic [WORD_WID-1:0]         rd_data
);

    localparam int unsigned BYTES   = (WORD_WID + 7) / 8;
    localparam int unsigned ENTRIES = 1 << ADDR_WID;

    logic [WORD_WID-1:0] mem [ENTRIES];
    logic [WORD_WID-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin : write_port
        if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Output holds between reads so the presented sample stays stable.
    always_comb begin : read_next
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin : read_reg
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/waveform_bram_buffer.sv
// Ping-pong sample buffer: refills the inactive bank from DMA while the consumer
// plays the active bank; banks swap only at a waveform boundary.
module waveform_bram_buffer
    import autoapproach_pkg::*;
#(
    parameter int unsigned WORD_WID      = 24,
    parameter int unsigned RAM_WID       = 32,
    parameter int unsigned RAM_WORD_WID  = 16,
    parameter int unsigned RAM_WORD_INCR = 2,
    parameter int unsigned DEPTH_WID     = 11
) (
    input  logic                  clk,
    input  logic                  rst_L,
    output logic [WORD_WID-1:0]   word,
    input  logic                  word_next,
    output logic                  word_ok,
    output logic                  word_last,
    input  logic                  word_rst,
    input  logic                  loop_en,
    output logic                  play_done,
    input  logic                  refresh_start,
    input  logic [RAM_WID-1:0]    start_addr,
    input  logic [DEPTH_WID-1:0]  refresh_last,
    output logic                  refresh_finished,
    output logic                  swap_pending,
    output logic                  active_bank,
    waveform_bram_buffer_if.master dma
);

    localparam int unsigned PARTS  = parts_f(WORD_WID, RAM_WORD_WID);
    localparam int unsigned PART_W = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int unsigned BYTES  = (WORD_WID + 7) / 8;
    localparam int unsigned WIDE_W = PARTS * RAM_WORD_WID;

    refresh_state_e             state_q, state_d;
    logic [RAM_WID-1:0]         addr_q, addr_d;
    logic                       read_q, read_d;
    logic                       tgt_q, tgt_d;
    logic [DEPTH_WID-1:0]       samp_q, samp_d;
    logic [DEPTH_WID-1:0]       rlast_q, rlast_d;
    logic [PART_W-1:0]          part_q, part_d;
    logic [1:0]                 valid_q, valid_d;
    logic [1:0][DEPTH_WID-1:0]  len_q, len_d;
    logic                       finished_q, finished_d;
    logic                       pending_q, pending_d;
    logic                       active_q, active_d;
    logic [DEPTH_WID-1:0]       index_q, index_d;
    logic                       ok_q, ok_d;
    logic                       last_q, last_d;
    logic                       done_q, done_d;

    logic                       fill_done_c;
    logic                       wr_en_c;
    logic [WORD_WID-1:0]        wr_data_c;
    logic [BYTES-1:0]           wr_be_c;
    logic [WIDE_W-1:0]          wide_c;
    int unsigned                part_lo_c;
    logic                       accept_c, at_last_c, swap_c;

    // Refresh FSM: one RAM read per request/valid round trip, parts written in place.
    always_comb begin : refresh_fsm
        state_d     = state_q;
        addr_d      = addr_q;
        read_d      = read_q;
        tgt_d       = tgt_q;
        samp_d      = samp_q;
        rlast_d     = rlast_q;
        part_d      = part_q;
        valid_d     = valid_q;
        len_d       = len_q;
        finished_d  = finished_q;
        fill_done_c = 1'b0;
        wr_en_c     = 1'b0;

        part_lo_c = RAM_WORD_WID * 32'(part_q);
        wide_c    = WIDE_W'(dma.ram_word) << part_lo_c;
        wr_data_c = wide_c[WORD_WID-1:0];
        wr_be_c   = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            wr_be_c[b] = (b * 8 >= part_lo_c) && (b * 8 < part_lo_c + RAM_WORD_WID);
        end

        case (state_q)
            RF_IDLE: begin
                if (refresh_start) begin
                    addr_d            = start_addr;
                    rlast_d           = refresh_last;
                    tgt_d             = ~active_q;
                    valid_d[~active_q] = 1'b0;
                    samp_d            = '0;
                    part_d            = '0;
                    state_d           = RF_REQ;
                end
            end
            RF_REQ: begin
                if (!read_q) begin
                    read_d = 1'b1;
                end else if (dma.ram_valid) begin
                    wr_en_c = 1'b1;
                    read_d  = 1'b0;
                    addr_d  = addr_q + RAM_WID'(RAM_WORD_INCR);
                    if (part_q == PART_W'(PARTS - 1)) begin
                        part_d = '0;
                        samp_d = samp_q + DEPTH_WID'(1);
                        if (samp_q == rlast_q) begin
                            valid_d[tgt_q] = 1'b1;
                            len_d[tgt_q]   = rlast_q;
                            fill_done_c    = 1'b1;
                            finished_d     = 1'b1;
                            state_d        = RF_WAIT_DEASSERT;
                        end
                    end else begin
                        part_d = part_q + PART_W'(1);
                    end
                end
            end
            RF_WAIT_DEASSERT: begin
                if (!refresh_start) begin
                    finished_d = 1'b0;
                    state_d    = RF_IDLE;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    // Playback handshake and bank swap; a swap never lands on a bank still being filled.
    always_comb begin : playback
        active_d  = active_q;
        index_d   = index_q;
        ok_d      = ok_q;
        last_d    = last_q;
        done_d    = done_q;
        pending_d = pending_q;

        at_last_c = (index_q == len_q[active_q]);
        accept_c  = word_next && !ok_q && valid_q[active_q] && !done_q && !word_rst;
        swap_c    = pending_q && valid_d[~active_q] &&
                    (word_rst || !valid_q[active_q] || done_q || (accept_c && at_last_c));

        if (ok_q && !word_next) ok_d = 1'b0;

        if (accept_c) begin
            ok_d    = 1'b1;
            last_d  = at_last_c;
            index_d = at_last_c ? '0 : index_q + DEPTH_WID'(1);
            if (at_last_c && !loop_en) done_d = 1'b1;
        end

        if (word_rst) begin
            index_d = '0;
            done_d  = 1'b0;
        end

        if (swap_c) begin
            active_d  = ~active_q;
            index_d   = '0;
            done_d    = 1'b0;
            pending_d = 1'b0;
        end else if (fill_done_c) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin : regs
        if (!rst_L) begin
            state_q    <= RF_IDLE;
            addr_q     <= '0;
            read_q     <= 1'b0;
            tgt_q      <= 1'b0;
            samp_q     <= '0;
            rlast_q    <= '0;
            part_q     <= '0;
            valid_q    <= '0;
            len_q      <= '0;
            finished_q <= 1'b0;
            pending_q  <= 1'b0;
            active_q   <= 1'b0;
            index_q    <= '0;
            ok_q       <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            tgt_q      <= tgt_d;
            samp_q     <= samp_d;
            rlast_q    <= rlast_d;
            part_q     <= part_d;
            valid_q    <= valid_d;
            len_q      <= len_d;
            finished_q <= finished_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            index_q    <= index_d;
            ok_q       <= ok_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    wave_bank_ram #(
        .WORD_WID (WORD_WID),
        .ADDR_WID (DEPTH_WID + 1)
    ) u_bank_ram (
        .clk     (clk),
        .rst_n   (rst_L),
        .wr_en   (wr_en_c),
        .wr_addr ({tgt_q, samp_q}),
        .wr_data (wr_data_c),
        .wr_be   (wr_be_c),
        .rd_en   (accept_c),
        .rd_addr ({active_q, index_q}),
        .rd_data (word)
    );

    assign word_ok          = ok_q;
    assign word_last        = last_q;
    assign play_done        = done_q;
    assign refresh_finished = finished_q;
    assign swap_pending     = pending_q;
    assign active_bank      = active_q;
    assign dma.ram_dma_addr = addr_q;
    assign dma.ram_read     = read_q;

endmodule

// File: doc/waveform_bram_buffer.md
Name: waveform_bram_buffer

Overview:
Double-buffered (ping-pong) sample buffer between the DMA RAM port and a sample consumer such as the autoapproach engine.
- Samples are WORD_WID bits wide and are assembled from PARTS little-endian RAM words.
- Each refresh fills the inactive bank with a programmable length. Playback continues from the active bank during a refresh.
- Banks swap only at a waveform boundary.
- Supports loop and one-shot playback.

Parameters:
WORD_WID, 24, sample width in bits.
RAM_WID, 32, DMA address width.
RAM_WORD_WID, 16, width of one RAM read.
RAM_WORD_INCR, 2, address increment per RAM read.
DEPTH_WID, 11, bank depth is 2**DEPTH_WID samples; also the width of the index and length registers.
PARTS (localparam), ceil(WORD_WID/RAM_WORD_WID), number of RAM reads per sample.

Ports:
clk  in  1  system clock
rst_L  in  1  asynchronous active-low reset
word  out  WORD_WID  current sample
word_next  in  1  consumer requests the next sample (four-phase)
word_ok  out  1  acknowledge for word_next; word is valid while high
word_last  out  1  the presented word is the last index of the active bank
word_rst  in  1  rewind playback to index 0
loop_en  in  1  1 = wrap after the last sample; 0 = one-shot
play_done  out  1  one-shot playback has finished
refresh_start  in  1  begin a refresh (level, four-phase)
start_addr  in  RAM_WID  DMA address of sample 0
refresh_last  in  DEPTH_WID  last sample index to load (length minus 1)
refresh_finished  out  1  refresh done; held until refresh_start falls
swap_pending  out  1  a filled bank is waiting to become active
active_bank  out  1  bank currently played
ram_dma_addr  out  RAM_WID  DMA read address
ram_word  in  RAM_WORD_WID  DMA read data
ram_read  out  1  DMA read request
ram_valid  in  1  DMA read data valid

Behaviour:
Reset (rst_L low, asynchronous):
- All outputs are 0.
- Both bank-valid flags and both stored lengths are 0; the refresh FSM is IDLE; the playback index is 0.
- Bank RAM contents are not reset.

Refresh FSM (states IDLE, REQ, WAIT_DEASSERT):
- IDLE: when refresh_start is high, latch start_addr into ram_dma_addr and latch refresh_last. The target is bank !active_bank; clear its valid flag; clear the sample and part counters. Go to REQ.
- REQ, when ram_read is low: set ram_read=1.
- REQ, when ram_read and ram_valid are both high:
  - Store ram_word into part p of the target sample, bits [p*RAM_WORD_WID +: RAM_WORD_WID], truncated at WORD_WID-1.
  - Set ram_read=0 and ram_dma_addr += RAM_WORD_INCR.
  - If p == PARTS-1: p=0 and the sample counter increments; otherwise p increments.
  - After the last part of sample refresh_last: set the target valid flag, store its length, set swap_pending=1, go to WAIT_DEASSERT.
- Each RAM read therefore costs at least 2 cycles plus the RAM latency. Minimum refresh time is (refresh_last+1)*PARTS*(latency+2) cycles.
- WAIT_DEASSERT: refresh_finished=1 while refresh_start is high. When refresh_start falls, refresh_finished=0 and the FSM returns to IDLE.
- refresh_start falling during REQ does not abort the refresh.
- A new refresh while swap_pending=1 overwrites the pending bank; the flag stays set.

Bank swap (at most one per cycle):
- When swap_pending=1, the swap happens on the cycle a word with word_last=1 is acknowledged.
- The swap also happens immediately if the active bank is not valid, if play_done=1, or on word_rst.
- A swap toggles active_bank, resets the index to 0, and clears swap_pending and play_done.

Playback handshake:
- word_rst has priority over everything else: index=0, play_done=0, and a pending swap is taken.
- If word_next=1, word_ok=0, the active bank is valid and play_done=0, the following happen on the next clock edge:
  - word <= bank[index] and word_ok <= 1;
  - word_last <= (index == stored length);
  - index increments, or wraps to 0 at the stored length.
- One-shot mode: after word_last is acknowledged with loop_en=0, play_done=1 and further requests are not acknowledged until word_rst or a swap.
- If word_next=0 and word_ok=1, then word_ok <= 0.
- A request against an invalid bank stays unacknowledged until a bank becomes valid.
- A length of 0 (refresh_last=0) is legal: every sample is last.

Decomposition:
- Shared package (autoapproach_pkg): the refresh-FSM state encoding and a function computing PARTS.
- One sub-module, wave_bank_ram: a dual-port RAM of 2**(DEPTH_WID+1) entries × WORD_WID bits with a byte-granular part-write enable. Its address is {bank, index}.
- The part-assembly write uses the part-enable, so no read-modify-write is needed.

Test Plan:
Bench parameters are DEPTH_WID=3, WORD_WID=24 and RAM latency 1.
- Refresh with refresh_last=3 from start_addr 0x100. Memory holds 16-bit words 0x1111,0x00AA, 0x2222,0x00BB, … → 8 reads at addresses 0x100–0x10E. refresh_finished=1 until refresh_start drops. Playback returns 0xAA1111, 0xBB2222, … and word_last is set on the 4th sample.
- Loop mode with loop_en=1: 10 handshakes → sample indices 0,1,2,3,0,1,2,3,0,1.
- One-shot mode with loop_en=0: after the 4th sample play_done=1, and a 5th request stays word_ok=0. word_rst then returns sample 0.
- Ping-pong: during playback of bank 0, refresh bank 1 with refresh_last=1 → bank 0 finishes the current pass. The swap happens on its word_last, and the next word is bank-1 sample 0.
- Simultaneous word_rst and word_next → index 0 and no acknowledge that cycle.
- rst_L pulsed low mid-refresh → ram_read=0 within the same cycle (asynchronous). Bank not valid and the request is not acknowledged. A fresh refresh then completes normally.
